// File: rtl/fifo_push_arb.sv
// Round-robin arbiter that hands the fifo push port to one requester at a time
// for a burst of up to BURST beats, stalling cleanly under fifo backpressure.
module fifo_push_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  push_o,
  output logic [WIDTH-1:0]      push_data_o,
  input  logic                  full_i,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  state_e          state_q;
  logic [IDXW-1:0] grant_q;
  logic [IDXW-1:0] rr_ptr_q;
  logic [IDXW-1:0] rr_ptr_d;
  logic [3:0]      beat_cnt_q;
  logic [NREQ-1:0] grant_oh_q;
  logic            busy_q;

  logic            sel_found;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW:0]   cand;
  logic            in_burst;
  logic            owner_valid;
  logic [WIDTH-1:0] owner_data;

  // Scanning from the farthest offset back toward rr_ptr lets the nearest valid requester win.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (req_valid_i[cand[IDXW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDXW-1:0];
      end
    end
  end

  assign in_burst    = (state_q == ST_BURST);
  assign owner_valid = req_valid_i[grant_q];
  assign rr_ptr_d    = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    owner_data  = '0;
    req_ready_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q == IDXW'(k)) begin
        owner_data     = req_data_i[k*WIDTH +: WIDTH];
        req_ready_o[k] = in_burst & ~full_i;
      end
    end
  end

  assign push_o      = in_burst & owner_valid & ~full_i;
  assign push_data_o = in_burst ? owner_data : '0;
  assign grant_o     = grant_oh_q;
  assign busy_o      = busy_q;

  // A full fifo freezes the burst entirely: no count, no release, no timeout.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_oh_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_q    <= ST_BURST;
            grant_q    <= sel_idx;
            beat_cnt_q <= '0;
            grant_oh_q <= NREQ'(1) << sel_idx;
            busy_q     <= 1'b1;
          end
        end
        ST_BURST: begin
          if (!full_i) begin
            if (!owner_valid || beat_cnt_q == LAST_BEAT) begin
              state_q    <= ST_IDLE;
              rr_ptr_q   <= rr_ptr_d;
              grant_oh_q <= '0;
              busy_q     <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Scoreboard bench for fifo_push_arb: behavioural requesters and a depth-4 fifo
// model drive the arbiter; every observed push is matched against expectations.
module tb_fifo_push_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  typedef struct packed {
    logic [1:0]  req;
    logic [31:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rstn_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  push_o;
  logic [WIDTH-1:0]      push_data_o;
  logic                  full_i;
  logic [NREQ-1:0]       grant_o;
  logic                  busy_o;

  exp_t        expQ[$];
  logic [31:0] srcQ[NREQ][$];
  logic [31:0] fifoQ[$];
  exp_t        monE;

  int testsRun     = 0;
  int testsFailed  = 0;
  int cycleCnt     = 0;
  int pushCount    = 0;
  int firstPushCyc = -1;
  int lastPushCyc  = -1;
  bit fifoMode     = 1'b0;

  logic [NREQ-1:0] accMask = '0;
  logic            pushNow = 1'b0;
  logic [31:0]     pdata   = '0;

  fifo_push_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .push_o     (push_o),
    .push_data_o(push_data_o),
    .full_i     (full_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: every push must match the head of the scoreboard.
  always @(negedge clk) begin
    if (push_o) begin
      pushCount++;
      if (firstPushCyc < 0) firstPushCyc = cycleCnt;
      lastPushCyc = cycleCnt;
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_push: got data %h grant %b, required no push", push_data_o, grant_o);
      end else begin
        monE = expQ.pop_front();
        if (push_data_o !== monE.data || grant_o !== (4'b0001 << monE.req)) begin
          testsFailed++;
          $display("[TB] FAIL push_beat: got data %h grant %b, required data %h grant %b",
                   push_data_o, grant_o, monE.data, 4'b0001 << monE.req);
        end
      end
    end
    testsRun++;
    if (!$onehot0(req_ready_o) || (push_o && full_i)) begin
      testsFailed++;
      $display("[TB] FAIL protocol: got ready %b push %b full %b, required onehot0 ready and no push while full",
               req_ready_o, push_o, full_i);
    end
  end

  // Capture handshakes just before the rising edge.
  always @(negedge clk) begin
    #4;
    accMask = req_valid_i & req_ready_o;
    pushNow = push_o;
    pdata   = push_data_o;
  end

  // Requesters and fifo model advance right after each rising edge.
  always @(posedge clk) begin
    cycleCnt++;
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (accMask[k] && srcQ[k].size() > 0) srcQ[k].delete(0);
    end
    if (fifoMode && pushNow) fifoQ.push_back(pdata);
    for (int k = 0; k < NREQ; k++) begin
      req_valid_i[k] = (srcQ[k].size() > 0);
      req_data_i[k*WIDTH +: WIDTH] = (srcQ[k].size() > 0) ? srcQ[k][0] : 32'h0;
    end
    #1;
    if (fifoMode) full_i = (fifoQ.size() >= 4);
  end

  task automatic flushAll();
    for (int k = 0; k < NREQ; k++) srcQ[k].delete();
    expQ.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rstn_i = 1'b0;
    flushAll();
    fifoMode = 1'b0;
    full_i   = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rstn_i = 1'b1;
  endtask

  task automatic loadReq(input int k, input logic [31:0] first, input int n, input int step);
    for (int b = 0; b < n; b++) begin
      srcQ[k].push_back(first + 32'(b * step));
      expQ.push_back('{req: 2'(k), data: first + 32'(b * step)});
    end
  endtask

  task automatic waitDrain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && busy_o == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rstn_i = 1'b0;
    full_i = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    for (int k = 0; k < NREQ; k++) srcQ[k].push_back(32'hAA00 + 32'(k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if ({req_ready_o, push_o, push_data_o, grant_o, busy_o} !== '0) begin
        testsFailed++;
        $display("[TB] FAIL reset_outputs: got ready %b push %b data %h grant %b busy %b, required all zero",
                 req_ready_o, push_o, push_data_o, grant_o, busy_o);
      end
    end
    for (int k = 0; k < NREQ; k++) srcQ[k].delete();
    @(negedge clk);
    #2;
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
    testsRun++;
    if ({req_ready_o, push_o, push_data_o, grant_o, busy_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL idle_outputs: got ready %b push %b data %h grant %b busy %b, required all zero",
               req_ready_o, push_o, push_data_o, grant_o, busy_o);
    end
    waitDrain(5, ok);
  endtask

  task automatic test_single();
    bit ok;
    int loadCyc;
    doReset();
    @(negedge clk);
    firstPushCyc = -1;
    loadCyc = cycleCnt;
    loadReq(2, 32'd10, 5, 1);
    waitDrain(40, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL single_drain: got %0d beats pending, required 0", expQ.size());
    end
    testsRun++;
    if (firstPushCyc !== loadCyc + 2) begin
      testsFailed++;
      $display("[TB] FAIL single_latency: got first push cycle %0d, required %0d", firstPushCyc, loadCyc + 2);
    end
    testsRun++;
    if (lastPushCyc - firstPushCyc !== 5) begin
      testsFailed++;
      $display("[TB] FAIL single_gap: got span %0d, required 5", lastPushCyc - firstPushCyc);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int loadCyc;
    doReset();
    @(negedge clk);
    firstPushCyc = -1;
    loadCyc = cycleCnt;
    for (int k = 0; k < NREQ; k++) begin
      for (int b = 0; b < 8; b++) srcQ[k].push_back(32'h100 * 32'(k) + 32'(b));
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int b = 0; b < BURST; b++) begin
          expQ.push_back('{req: 2'(k), data: 32'h100 * 32'(k) + 32'(r * BURST + b)});
        end
      end
    end
    waitDrain(200, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL rr_drain: got %0d beats pending, required 0", expQ.size());
    end
    testsRun++;
    if (firstPushCyc !== loadCyc + 2 || lastPushCyc - firstPushCyc !== 38) begin
      testsFailed++;
      $display("[TB] FAIL rr_throughput: got first %0d span %0d, required first %0d span 38",
               firstPushCyc, lastPushCyc - firstPushCyc, loadCyc + 2);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int base;
    doReset();
    @(negedge clk);
    firstPushCyc = -1;
    base = pushCount;
    loadReq(1, 32'h20, 6, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pushCount == base + 2) seen = 1'b1;
    end
    testsRun++;
    if (!seen) begin
      testsFailed++;
      $display("[TB] FAIL bp_start_timeout: got %0d pushes, required 2", pushCount - base);
    end
    @(posedge clk);
    #1;
    full_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      testsRun++;
      if (push_o !== 1'b0 || req_ready_o !== 4'b0000 || busy_o !== 1'b1 || grant_o !== 4'b0010) begin
        testsFailed++;
        $display("[TB] FAIL bp_stall: got push %b ready %b busy %b grant %b, required 0 0000 1 0010",
                 push_o, req_ready_o, busy_o, grant_o);
      end
    end
    @(posedge clk);
    #1;
    full_i = 1'b0;
    waitDrain(40, ok);
    testsRun++;
    if (!ok || lastPushCyc - firstPushCyc !== 9) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume: got drained %b span %0d, required 1 span 9", ok, lastPushCyc - firstPushCyc);
    end
  endtask

  task automatic test_early_release();
    bit ok;
    doReset();
    @(negedge clk);
    firstPushCyc = -1;
    loadReq(0, 32'hA0, 2, 1);
    loadReq(3, 32'hD0, 2, 1);
    waitDrain(40, ok);
    testsRun++;
    if (!ok || lastPushCyc - firstPushCyc !== 5) begin
      testsFailed++;
      $display("[TB] FAIL early_release: got drained %b span %0d, required 1 span 5", ok, lastPushCyc - firstPushCyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit seen;
    int base;
    doReset();
    @(negedge clk);
    base = pushCount;
    loadReq(2, 32'h30, 4, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pushCount == base + 2) seen = 1'b1;
    end
    testsRun++;
    if (!seen || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL mid_burst_setup: got pushes %0d busy %b, required 2 and 1", pushCount - base, busy_o);
    end
    #1;
    rstn_i = 1'b0;
    #1;
    testsRun++;
    if ({req_ready_o, push_o, push_data_o, grant_o, busy_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got ready %b push %b data %h grant %b busy %b, required all zero",
               req_ready_o, push_o, push_data_o, grant_o, busy_o);
    end
    flushAll();
    repeat (2) @(negedge clk);
    #2;
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
    testsRun++;
    if ({req_ready_o, push_o, push_data_o, grant_o, busy_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset: got ready %b push %b data %h grant %b busy %b, required all zero",
               req_ready_o, push_o, push_data_o, grant_o, busy_o);
    end
    loadReq(0, 32'h50, 2, 1);
    loadReq(2, 32'h40, 2, 1);
    waitDrain(40, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_order: got %0d beats pending, required 0", expQ.size());
    end
  endtask

  task automatic test_fifo_integration();
    bit ok;
    bit seen;
    int base;
    logic [31:0] popped;
    logic [31:0] want[4];
    want[0] = 32'd12; want[1] = 32'd14; want[2] = 32'd16; want[3] = 32'd18;
    doReset();
    fifoQ.delete();
    fifoMode = 1'b1;
    @(negedge clk);
    base = pushCount;
    loadReq(0, 32'd10, 5, 2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pushCount == base + 4) seen = 1'b1;
    end
    repeat (6) @(negedge clk);
    #1;
    testsRun++;
    if (!seen || pushCount - base !== 4 || full_i !== 1'b1 || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fifo_full_hold: got pushes %0d full %b busy %b, required 4 1 1", pushCount - base, full_i, busy_o);
    end
    @(posedge clk);
    #1;
    popped = (fifoQ.size() > 0) ? fifoQ.pop_front() : 32'hDEAD;
    testsRun++;
    if (popped !== 32'd10) begin
      testsFailed++;
      $display("[TB] FAIL fifo_pop0: got %0d, required 10", popped);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pushCount == base + 5) seen = 1'b1;
    end
    testsRun++;
    if (!seen) begin
      testsFailed++;
      $display("[TB] FAIL fifo_fifth_push: got %0d pushes, required 5", pushCount - base);
    end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      popped = (fifoQ.size() > 0) ? fifoQ.pop_front() : 32'hDEAD;
      testsRun++;
      if (popped !== want[j]) begin
        testsFailed++;
        $display("[TB] FAIL fifo_pop%0d: got %0d, required %0d", j + 1, popped, want[j]);
      end
    end
    waitDrain(20, ok);
    testsRun++;
    if (!ok || fifoQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL fifo_drain: got drained %b fifo level %0d, required 1 and 0", ok, fifoQ.size());
    end
    fifoMode = 1'b0;
    full_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_fifo_integration();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter WIDTH, default 32: data width of each requester and of the fifo push port.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 Parameter BURST, default 4: maximum accepted beats per grant, 1..15.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  NREQ  per-requester beat valid.
REQ-007 req_data_i  input  NREQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 req_ready_o  output  NREQ  per-requester accept; a beat transfers when valid and ready are both 1 on a rising edge.
REQ-009 push_o  output  1  push strobe to fifo push_i.
REQ-010 push_data_o  output  WIDTH  data to fifo push_data_i.
REQ-011 full_i  input  1  from fifo full_o.
REQ-012 grant_o  output  NREQ  one-hot current owner; all zero when idle.
REQ-013 busy_o  output  1  1 while in BURST state.

Function
REQ-014 FSM has two states, IDLE and BURST; registers: state, grant_q (index), rr_ptr (index), beat_cnt (4 bits).
REQ-015 IDLE, no req_valid_i bit set: stay IDLE; all outputs 0.
REQ-016 IDLE, any valid bit set: select the first set bit at or after rr_ptr, wrapping modulo NREQ; load grant_q with it; clear beat_cnt; go to BURST next cycle (one-cycle arbitration latency, no transfer in the IDLE cycle).
REQ-017 BURST outputs: req_ready_o[grant_q] = !full_i, other ready bits 0; push_o = req_valid_i[grant_q] & !full_i; push_data_o = req_data_i of grant_q; grant_o = one-hot(grant_q); busy_o = 1.
REQ-018 Outside BURST: push_data_o = 0 and grant_o = 0.
REQ-019 A beat is counted only when push_o = 1; beat_cnt increments by 1.
REQ-020 full_i = 1 in BURST: hold state, no count, no transfer, no timeout.
REQ-021 BURST exit when push_o = 1 and beat_cnt = BURST-1: go to IDLE; rr_ptr <= (grant_q+1) mod NREQ.
REQ-022 BURST exit when req_valid_i[grant_q] = 0 and full_i = 0: go to IDLE; rr_ptr <= (grant_q+1) mod NREQ.
REQ-023 req_valid_i[grant_q] = 0 while full_i = 1: stay in BURST.
REQ-024 Valid bits of non-granted requesters never change grant_q during BURST.
REQ-025 At most one req_ready_o bit is ever 1; push_o = 1 implies full_i = 0 in the same cycle.
REQ-026 Minimum gap between bursts is one IDLE cycle; sustained throughput is BURST beats per BURST+1 cycles.

Reset
REQ-027 rstn_i low, asynchronously at any time including mid-burst: state=IDLE, grant_q=0, rr_ptr=0, beat_cnt=0.
REQ-028 During and immediately after reset: req_ready_o=0, push_o=0, push_data_o=0, grant_o=0, busy_o=0.
REQ-029 After rstn_i deasserts, the first arbitration starts from requester 0; an interrupted burst is not resumed.

Verification
REQ-030 Single requester: only req 2 valid, data 10,11,12,13,14, full_i=0 -> IDLE 1 cycle, pushes 10..13 on 4 consecutive edges, IDLE 1 cycle, then 14 pushed; grant_o=0100 while busy.
REQ-031 Round robin: all 4 valid continuously -> grant order 0,1,2,3,0, each 4 beats, one idle cycle between bursts.
REQ-032 Backpressure: req 1 bursting, full_i=1 for 3 cycles after beat 2 -> push_o=0 and ready=0 for those 3 cycles, beat_cnt held at 2, then beats 3 and 4 pushed, IDLE.
REQ-033 Early release: req 0 drops valid after 2 beats with req 3 valid -> IDLE, rr_ptr=1, req 3 granted next.
REQ-034 Reset mid-burst: rstn_i low during beat 2 of req 2 -> all outputs 0 immediately; after release with req 2 and req 0 both valid, req 0 granted first.
REQ-035 Integration with a depth-4 fifo: req 0 pushes 10,12,14,16, fifo full_o rises -> no 5th push until a fifo pop; popped data 10,12,14,16 in order.
